// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - RV32I integer register file, 2 async read ports, 1 sync write port
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module reg_file_2r1w #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   dbg_a,
    output logic [XLEN-1:0] dbg_d
);

    if (NREGS != 2 ** AW) begin : g_bad_cfg
        $error("reg_file_2r1w: NREGS must equal 2**AW");
    end

    // x0 has no storage; reads of address 0 are forced to zero below
    logic [XLEN-1:0] mem [1:NREGS-1];
    logic            fwd_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign fwd_en = rst_n && we && (wa != '0);
`else
    assign fwd_en = 1'b0;
`endif

    assign rd1   = (ra1 == '0)   ? '0 : (fwd_en && (ra1 == wa))   ? wd : mem[ra1];
    assign rd2   = (ra2 == '0)   ? '0 : (fwd_en && (ra2 == wa))   ? wd : mem[ra2];
    assign dbg_d = (dbg_a == '0) ? '0 : (fwd_en && (dbg_a == wa)) ? wd : mem[dbg_a];

endmodule
